// File: rtl/age_iqueue_pkg.sv
// Shared constants and helpers for the age-ordered issue queue.
package age_iqueue_pkg;

    localparam int IQ_NSRC = 2;

    // Conservative room check: a full rename group must always fit.
    function automatic logic iq_full(input int count, input int wr, input int qlen);
        return (count + wr > qlen);
    endfunction

endpackage

// File: rtl/age_iqueue_if.sv
// Write-group, wakeup and issue bundle of the age-ordered issue queue.
interface age_iqueue_if #(
    parameter int QLEN      = 8,
    parameter int WR        = 4,
    parameter int RD        = 2,
    parameter int WAKE      = 4,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 96
);
    localparam int CW = $clog2(QLEN + 1);

    logic                      flush;
    logic                      wen;
    logic [WR-1:0]             wvalid;
    logic [WR*PREG_W-1:0]      wdst;
    logic [WR*2*PREG_W-1:0]    wsrc_pid;
    logic [WR*2-1:0]           wsrc_rdy;
    logic [WR*PAYLOAD_W-1:0]   wpayload;
    logic [WAKE-1:0]           wake_valid;
    logic [WAKE*PREG_W-1:0]    wake_pid;
    logic [RD-1:0]             issue_valid;
    logic [RD-1:0]             issue_ready;
    logic [RD*PREG_W-1:0]      issue_dst;
    logic [RD*2*PREG_W-1:0]    issue_src_pid;
    logic [RD*PAYLOAD_W-1:0]   issue_payload;
    logic                      full;
    logic [CW-1:0]             count;

    modport slave (
        input  flush, wen, wvalid, wdst, wsrc_pid, wsrc_rdy, wpayload,
        input  wake_valid, wake_pid, issue_ready,
        output issue_valid, issue_dst, issue_src_pid, issue_payload, full, count
    );

    modport master (
        output flush, wen, wvalid, wdst, wsrc_pid, wsrc_rdy, wpayload,
        output wake_valid, wake_pid, issue_ready,
        input  issue_valid, issue_dst, issue_src_pid, issue_payload, full, count
    );

endinterface

// File: rtl/age_iqueue_select.sv
// iq_select: picks the RD lowest-index (oldest) set bits of an eligibility vector.
module iq_select #(
    parameter int QLEN = 8,
    parameter int RD   = 2,
    parameter int IW   = $clog2(QLEN)
) (
    input  logic [QLEN-1:0]          elig,
    output logic [RD-1:0]            sel_valid,
    output logic [RD-1:0][QLEN-1:0]  sel_onehot,
    output logic [RD-1:0][IW-1:0]    sel_idx
);

    logic [QLEN-1:0] rem_s;
    logic            found_s;

    // Successive find-first: each slot masks off what earlier slots took.
    always_comb begin
        rem_s      = elig;
        found_s    = 1'b0;
        sel_valid  = '0;
        sel_onehot = '0;
        sel_idx    = '0;
        for (int j = 0; j < RD; j++) begin
            found_s = 1'b0;
            for (int i = 0; i < QLEN; i++) begin
                if (rem_s[i] && !found_s) begin
                    found_s          = 1'b1;
                    sel_onehot[j][i] = 1'b1;
                    sel_idx[j]       = IW'(i);
                end else begin
                    found_s = found_s;
                end
            end
            sel_valid[j] = found_s;
            rem_s        = rem_s & ~sel_onehot[j];
        end
    end

endmodule

// File: rtl/age_iqueue.sv
// Age-ordered collapsing issue queue. Optional same-cycle wake-to-select
// bypass is enabled by defining IQ_WAKE_BYPASS_EN.
module age_iqueue
    import age_iqueue_pkg::*;
#(
    parameter int QLEN      = 8,
    parameter int WR        = 4,
    parameter int RD        = 2,
    parameter int WAKE      = 4,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 96
) (
    input  logic         clk,
    input  logic         reset,
    age_iqueue_if.slave  bus
);

    localparam int IW = $clog2(QLEN);
    localparam int CW = $clog2(QLEN + 1);
    localparam logic [CW-1:0] QLEN_C = CW'(QLEN);

    typedef struct packed {
        logic [PREG_W-1:0] pid;
        logic              rdy;
    } iq_src_t;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    dst;
        iq_src_t [IQ_NSRC-1:0] src;
        logic [PAYLOAD_W-1:0] payload;
    } iq_wentry_t;

    iq_wentry_t             ent_q [QLEN];
    iq_wentry_t             ent_d [QLEN];
    iq_wentry_t             mv_s;
    logic [CW-1:0]          count_q, count_d, wp_s;
    logic [QLEN-1:0]        elig_s, acc_s;
    logic                   full_s, wr_en_s;
    logic [RD-1:0]          sel_valid_s;
    logic [RD-1:0][QLEN-1:0] sel_onehot_s;
    logic [RD-1:0][IW-1:0]  sel_idx_s;

    function automatic logic woken(input logic [PREG_W-1:0] pid,
                                   input logic [WAKE-1:0] wv,
                                   input logic [WAKE*PREG_W-1:0] wpid);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WAKE; k++) begin
            if (wv[k] && (wpid[k*PREG_W +: PREG_W] == pid)) hit = 1'b1;
            else hit = hit;
        end
        return hit;
    endfunction

    assign full_s    = iq_full(int'(count_q), WR, QLEN);
    assign wr_en_s   = bus.wen && !full_s && !bus.flush;
    assign bus.full  = full_s;
    assign bus.count = count_q;

    // Eligibility: occupied entry with both sources ready.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < QLEN; i++) begin
`ifdef IQ_WAKE_BYPASS_EN
            elig_s[i] = (CW'(i) < count_q)
                && (ent_q[i].src[0].rdy || woken(ent_q[i].src[0].pid, bus.wake_valid, bus.wake_pid))
                && (ent_q[i].src[1].rdy || woken(ent_q[i].src[1].pid, bus.wake_valid, bus.wake_pid));
`else
            elig_s[i] = (CW'(i) < count_q) && ent_q[i].src[0].rdy && ent_q[i].src[1].rdy;
`endif
        end
    end

    iq_select #(.QLEN(QLEN), .RD(RD), .IW(IW)) u_select (
        .elig       (elig_s),
        .sel_valid  (sel_valid_s),
        .sel_onehot (sel_onehot_s),
        .sel_idx    (sel_idx_s)
    );

    // Issue slot muxing and accepted-entry mask.
    always_comb begin
        bus.issue_valid   = sel_valid_s & {RD{~reset}};
        bus.issue_dst     = '0;
        bus.issue_src_pid = '0;
        bus.issue_payload = '0;
        acc_s             = '0;
        for (int j = 0; j < RD; j++) begin
            bus.issue_dst[j*PREG_W +: PREG_W]             = ent_q[sel_idx_s[j]].dst;
            bus.issue_src_pid[(j*2)*PREG_W +: PREG_W]     = ent_q[sel_idx_s[j]].src[0].pid;
            bus.issue_src_pid[(j*2+1)*PREG_W +: PREG_W]   = ent_q[sel_idx_s[j]].src[1].pid;
            bus.issue_payload[j*PAYLOAD_W +: PAYLOAD_W]   = ent_q[sel_idx_s[j]].payload;
            if (sel_valid_s[j] && bus.issue_ready[j]) acc_s = acc_s | sel_onehot_s[j];
            else acc_s = acc_s;
        end
    end

    // Next state: collapse survivors toward index 0, then append the write group.
    always_comb begin
        wp_s = '0;
        mv_s = '0;
        for (int i = 0; i < QLEN; i++) begin
            ent_d[i]       = ent_q[i];
            ent_d[i].valid = 1'b0;
        end
        for (int i = 0; i < QLEN; i++) begin
            if ((CW'(i) < count_q) && !acc_s[i]) begin
                mv_s       = ent_q[i];
                mv_s.valid = 1'b1;
                for (int k = 0; k < IQ_NSRC; k++) begin
                    mv_s.src[k].rdy = mv_s.src[k].rdy
                        | woken(mv_s.src[k].pid, bus.wake_valid, bus.wake_pid);
                end
                ent_d[wp_s[IW-1:0]] = mv_s;
                wp_s = wp_s + CW'(1);
            end else begin
                wp_s = wp_s;
            end
        end
        for (int s = 0; s < WR; s++) begin
            if (wr_en_s && bus.wvalid[s] && (wp_s < QLEN_C)) begin
                mv_s.valid   = 1'b1;
                mv_s.dst     = bus.wdst[s*PREG_W +: PREG_W];
                mv_s.payload = bus.wpayload[s*PAYLOAD_W +: PAYLOAD_W];
                for (int k = 0; k < IQ_NSRC; k++) begin
                    mv_s.src[k].pid = bus.wsrc_pid[(s*2+k)*PREG_W +: PREG_W];
                    mv_s.src[k].rdy = bus.wsrc_rdy[s*2+k]
                        | woken(bus.wsrc_pid[(s*2+k)*PREG_W +: PREG_W], bus.wake_valid, bus.wake_pid);
                end
                ent_d[wp_s[IW-1:0]] = mv_s;
                wp_s = wp_s + CW'(1);
            end else begin
                wp_s = wp_s;
            end
        end
        if (bus.flush) begin
            for (int i = 0; i < QLEN; i++) ent_d[i].valid = 1'b0;
            wp_s = '0;
        end else begin
            wp_s = wp_s;
        end
        count_d = wp_s;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < QLEN; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

endmodule
